excp_ita: RTL
=============

Name: excp_ita

Overview:
- Interrupt arbitration stage directly upstream of the exception IRQ unit.
- Synchronises the raw external interrupt and registers the software/timer lines.
- Opens a delivery window only at safe commit points: valid, non-jump instruction, no flush, or core in WFI.
- Drives the gated ext/sft/tmr levels consumed by IRQ masking/cause logic; applies a post-acknowledge hold-off so mstatus.MIE clearing propagates before re-presenting.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for ext_irq_i; legal range 2..4.
- HOLDOFF, 2: cycles outputs are forced low after irq_ack; legal range 0..15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ext_irq_i  in  1  external interrupt level, asynchronous to clk
- sft_irq_i  in  1  software interrupt level, clk domain
- tmr_irq_i  in  1  timer interrupt level, clk domain
- commit_vld  in  1  valid instruction at commit this cycle
- commit_is_jump  in  1  committing instruction is a jump/branch
- flush_busy  in  1  pipeline flush or trap entry in progress
- wfi_flag_r  in  1  core sleeping in WFI
- irq_ack  in  1  trap entry for an interrupt taken this cycle
- ita_o_pend  out  3  registered pending {ext,tmr,sft}, for mip mirroring
- ita_o_ext_irq  out  1  gated external interrupt
- ita_o_sft_irq  out  1  gated software interrupt
- ita_o_tmr_irq  out  1  gated timer interrupt

Behaviour:
- Synchronous active-high reset: all sync flops, pend, snap and cnt = 0; state = IDLE; all outputs 0.
- pend[2] (ext) = ext_irq_i after SYNC_STAGES flops. pend[1] (tmr) and pend[0] (sft) = inputs after 1 flop. All lines are level-sensitive; no edge latching.
- window = ~flush_busy & (wfi_flag_r | (commit_vld & ~commit_is_jump)), combinational.
- Gated outputs: ita_o_x = (state==PRESENT) & snap[x] & pend[x], combinational from registers only (glitch-free with respect to commit inputs).
- FSM (one transition per cycle; priority is listed order):
  - IDLE: |pend → ARM.
  - ARM: ~|pend → IDLE; else window → PRESENT with snap <= pend.
  - PRESENT:
    - irq_ack → HOLDOFF with cnt <= HOLDOFF-1; if HOLDOFF==0, go directly to IDLE/ARM per |pend.
    - else ~|(snap & pend) → IDLE.
    - else ~window → ARM (outputs drop the next cycle).
    - else stay; snap <= snap | pend, so newly arriving sources join.
  - HOLDOFF: outputs 0; cnt decrements; at cnt==0 → ARM if |pend else IDLE.
- Latency:
  - sft/tmr input to gated output: min 3 cycles (flop, IDLE→ARM, ARM→PRESENT).
  - ext: SYNC_STAGES+2 cycles.
- irq_ack outside PRESENT is ignored (no state change).
- Source deasserts while in PRESENT: that output drops the cycle after pend clears. If all drop → IDLE with no ack required.
- Simultaneous irq_ack and source drop: ack wins → HOLDOFF.
- wfi_flag_r=1 with commit_vld=0 still opens the window, so the core can wake.
- Reset asserted in any state (including HOLDOFF mid-count) → IDLE the next cycle, outputs 0. Synchroniser contents are discarded.
- cnt is 4 bits wide and does not wrap: it saturates at 0.

Test Plan:
1. Reset, then tmr_irq_i=1 at cycle 0 with commit_vld=1 and commit_is_jump=0 → ita_o_pend=3'b010 at cycle 1; ita_o_tmr_irq=1 at cycle 3; others 0.
2. ext_irq_i pulse held high with SYNC_STAGES=2, window open → ita_o_pend[2]=1 after 2 cycles; ita_o_ext_irq=1 at cycle 4.
3. sft pending, commit_is_jump=1 for 5 cycles then 0 → output stays 0 throughout the jump; asserts the cycle after the jump clears. A jump arriving while in PRESENT drops the output within 1 cycle.
4. In PRESENT, pulse irq_ack with HOLDOFF=2 and tmr still high → output 0 for exactly 2 cycles, then ARM; re-asserts 1 cycle later.
5. wfi_flag_r=1, commit_vld=0, sft_irq_i=1 → ita_o_sft_irq=1 at cycle 3. With wfi_flag_r=0 and flush_busy=1 instead → stays 0.
6. Assert rst during HOLDOFF (cnt=1) with tmr high → outputs 0, state IDLE. After release, re-presents at the normal 3-cycle latency.

Source files
------------

// File: rtl/excp_ita.sv
// Interrupt arbitration ahead of the IRQ unit: synchronises/registers the raw
// interrupt levels and presents them only while the core sits at a safe commit point.
module excp_ita #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_irq_i,
  input  logic       sft_irq_i,
  input  logic       tmr_irq_i,
  input  logic       commit_vld,
  input  logic       commit_is_jump,
  input  logic       flush_busy,
  input  logic       wfi_flag_r,
  input  logic       irq_ack,
  output logic [2:0] ita_o_pend,
  output logic       ita_o_ext_irq,
  output logic       ita_o_sft_irq,
  output logic       ita_o_tmr_irq
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_PRESENT, S_HOLD} state_t;

  localparam logic [3:0] HOLD_INIT = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  state_t                   state_reg, state_next;
  logic [SYNC_STAGES-2:0]   ext_sync_reg;
  logic [2:0]               pend_reg;
  logic [2:0]               snap_reg, snap_next;
  logic [3:0]               cnt_reg, cnt_next;
  logic                     window;
  logic                     any_pend;
  logic [2:0]               gated;

  // The last ext synchroniser stage is pend_reg[2] itself, giving SYNC_STAGES flops total.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync_reg <= '0;
      pend_reg     <= '0;
    end else begin
      ext_sync_reg[0] <= ext_irq_i;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        ext_sync_reg[i] <= ext_sync_reg[i-1];
      end
      pend_reg <= {ext_sync_reg[SYNC_STAGES-2], tmr_irq_i, sft_irq_i};
    end
  end

  assign window   = ~flush_busy & (wfi_flag_r | (commit_vld & ~commit_is_jump));
  assign any_pend = |pend_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      snap_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      snap_reg  <= snap_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    snap_next  = snap_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (any_pend) state_next = S_ARM;
      end
      S_ARM: begin
        if (!any_pend) begin
          state_next = S_IDLE;
        end else if (window) begin
          state_next = S_PRESENT;
          snap_next  = pend_reg;
        end
      end
      S_PRESENT: begin
        // An acknowledge beats a simultaneous source drop so MIE clearing always gets its hold-off.
        if (irq_ack) begin
          if (HOLDOFF == 0) begin
            state_next = any_pend ? S_ARM : S_IDLE;
          end else begin
            state_next = S_HOLD;
            cnt_next   = HOLD_INIT;
          end
        end else if (~|(snap_reg & pend_reg)) begin
          state_next = S_IDLE;
        end else if (!window) begin
          state_next = S_ARM;
        end else begin
          snap_next = snap_reg | pend_reg;
        end
      end
      S_HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = any_pend ? S_ARM : S_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Driven purely from registers so commit-side glitches never reach the IRQ unit.
  assign gated         = {3{state_reg == S_PRESENT}} & snap_reg & pend_reg;
  assign ita_o_pend    = pend_reg;
  assign ita_o_ext_irq = gated[2];
  assign ita_o_tmr_irq = gated[1];
  assign ita_o_sft_irq = gated[0];

endmodule
